// File: rtl/i2c_target.sv
// i2c_target: I2C target engine; matches a 7-bit address, writes bytes to rx_data, reads from tx_data.
// Latency: bus events act SYNC_STAGES+1 clk after the pin change; rx_valid and tx_req are 1-clk pulses.
// Backpressure: none; SCL is never stretched, host must refresh tx_data within one SCL low phase of tx_req.
// Build option: define I2C_GENERAL_CALL_EN to ACK the general call byte 8'h00 as a write.
module i2c_target #(
    parameter logic [6:0] ADDR        = 7'h42,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       busy
);

    // Fewer than two synchroniser flops is not metastability-safe, so clamp.
    localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_RX_BYTE,
        ST_RX_ACK,
        ST_TX_BYTE,
        ST_TX_ACK,
        ST_WAIT_STOP
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronisers and edge/condition detection
    // ------------------------------------------------------------------
    logic [SYNC_N-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_N-1:0] sda_sync_q, sda_sync_d;
    logic              scl_hist_q, scl_hist_d;
    logic              sda_hist_q, sda_hist_d;

    logic scl_s, sda_s;
    logic scl_rise, scl_fall;
    logic start_det, stop_det;

    // Shift the raw pins through the sync chain; history holds the previous synced level.
    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_N-2:0], scl_in};
        sda_sync_d = {sda_sync_q[SYNC_N-2:0], sda_in};
        scl_hist_d = scl_sync_q[SYNC_N-1];
        sda_hist_d = sda_sync_q[SYNC_N-1];
    end

    // Sync and history flops reset to the idle-bus level (high) so reset creates no false edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_hist_q <= scl_hist_d;
            sda_hist_q <= sda_hist_d;
        end
    end

    // START/STOP need SCL high on both samples so an SDA change at an SCL edge never qualifies.
    always_comb begin
        scl_s     = scl_sync_q[SYNC_N-1];
        sda_s     = sda_sync_q[SYNC_N-1];
        scl_rise  = scl_s & ~scl_hist_q;
        scl_fall  = ~scl_s & scl_hist_q;
        start_det = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
        stop_det  = scl_s & scl_hist_q & ~sda_hist_q & sda_s;
    end

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t     state_q, state_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       byte_done_q, byte_done_d;
    logic       rw_q, rw_d;
    logic       mack_q, mack_d;
    logic       sda_oe_q, sda_oe_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       tx_req_q, tx_req_d;
    logic       busy_q, busy_d;

    logic [7:0] shift_in;
    logic       addr_hit;

    // Address decode on the byte as it completes; 8'h00/8'h01 never match the own address.
    always_comb begin
        shift_in = {shift_q[6:0], sda_s};
        addr_hit = (shift_in[7:1] == ADDR) && (shift_in[7:1] != 7'h00);
`ifdef I2C_GENERAL_CALL_EN
        if (shift_in == 8'h00) begin
            addr_hit = 1'b1;
        end
`endif
    end

    // Next-state logic: STOP beats START beats SCL edges; SDA drive changes only on SCL fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_done_d = byte_done_q;
        rw_d        = rw_q;
        mack_d      = mack_q;
        sda_oe_d    = sda_oe_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_req_d    = 1'b0;

        if (stop_det) begin
            state_d     = ST_IDLE;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            mack_d      = 1'b0;
        end else if (start_det) begin
            state_d     = ST_ADDR;
            sda_oe_d    = 1'b0;
            bit_cnt_d   = 3'd0;
            byte_done_d = 1'b0;
            mack_d      = 1'b0;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rw_d = shift_in[0];
                            if (addr_hit) begin
                                byte_done_d = 1'b1;
                            end else begin
                                state_d = ST_WAIT_STOP;
                            end
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = 1'b1;
                        state_d     = ST_ADDR_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    // Any fall seen here ends the 9th (ACK) pulse.
                    if (scl_fall) begin
                        bit_cnt_d = 3'd0;
                        if (rw_q) begin
                            shift_d  = tx_data;
                            tx_req_d = 1'b1;
                            sda_oe_d = ~tx_data[7];
                            state_d  = ST_TX_BYTE;
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RX_BYTE;
                        end
                    end
                end
                ST_RX_BYTE: begin
                    if (scl_rise) begin
                        shift_d   = shift_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            rx_data_d   = shift_in;
                            rx_valid_d  = 1'b1;
                            byte_done_d = 1'b1;
                        end
                    end else if (scl_fall && byte_done_q) begin
                        byte_done_d = 1'b0;
                        sda_oe_d    = 1'b1;
                        state_d     = ST_RX_ACK;
                    end
                end
                ST_RX_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = ST_RX_BYTE;
                    end
                end
                ST_TX_BYTE: begin
                    // bit_cnt counts bits already clocked out; the MSB goes out on entry.
                    if (scl_fall) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d = 1'b0;
                            mack_d   = 1'b0;
                            state_d  = ST_TX_ACK;
                        end else begin
                            shift_d  = {shift_q[6:0], 1'b0};
                            sda_oe_d = ~shift_q[6];
                        end
                    end
                end
                ST_TX_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_WAIT_STOP;
                        end else begin
                            mack_d = 1'b1;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d    = 1'b0;
                        bit_cnt_d = 3'd0;
                        shift_d   = tx_data;
                        tx_req_d  = 1'b1;
                        sda_oe_d  = ~tx_data[7];
                        state_d   = ST_TX_BYTE;
                    end
                end
                default: begin
                    // IDLE and WAIT_STOP ignore SCL; only START/STOP move them.
                end
            endcase
        end

        busy_d = (state_d == ST_ADDR_ACK) || (state_d == ST_RX_BYTE) ||
                 (state_d == ST_RX_ACK)   || (state_d == ST_TX_BYTE) ||
                 (state_d == ST_TX_ACK);
    end

    // FSM state and registered outputs; async reset releases SDA immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'h00;
            byte_done_q <= 1'b0;
            rw_q        <= 1'b0;
            mack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_req_q    <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_done_q <= byte_done_d;
            rw_q        <= rw_d;
            mack_q      <= mack_d;
            sda_oe_q    <= sda_oe_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_req_q    <= tx_req_d;
            busy_q      <= busy_d;
        end
    end

    assign sda_oe   = sda_oe_q;
    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign tx_req   = tx_req_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bus-level bench for i2c_target; a behavioural I2C controller drives SCL/SDA,
// a wired-AND models the open-drain SDA line, and a transaction-level model predicts ACKs and data.
// Build option: I2C_GENERAL_CALL_EN changes the expected general-call outcome.
`timescale 1ns/1ps
module tb_i2c_target;

    localparam logic [6:0] ADDR_P = 7'h42;
    localparam int         Q      = 10;   // clk cycles per quarter SCL period (SCL = clk/40)

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic [7:0] tx_data = 8'h00;
    logic       tx_req;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    // Monitor counters, written only by the monitor process.
    int rxv_cnt  = 0;
    int txr_cnt  = 0;
    int oe_cnt   = 0;
    int busy_cnt = 0;

    // Reference model state: last byte the target should hold in rx_data.
    logic [7:0] exp_rx = 8'h00;

    assign sda_bus = sda_m & ~sda_oe;

    always #5 clk = ~clk;

    i2c_target #(.ADDR(ADDR_P), .SYNC_STAGES(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .scl_in   (scl_m),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .busy     (busy)
    );

    always @(negedge clk) begin
        if (rx_valid) rxv_cnt  <= rxv_cnt + 1;
        if (tx_req)   txr_cnt  <= txr_cnt + 1;
        if (sda_oe)   oe_cnt   <= oe_cnt + 1;
        if (busy)     busy_cnt <= busy_cnt + 1;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion by 3 ms, want completion");
        $fatal(1, "watchdog expired");
    end

    // Address rule: own address (R or W), never 7'h00 unless general call is built in (write only).
    function automatic logic model_ack(input logic [7:0] b);
`ifdef I2C_GENERAL_CALL_EN
        if (b == 8'h00) return 1'b1;
`endif
        return (b[7:1] == ADDR_P) && (b[7:1] != 7'h00);
    endfunction

    // ---------------- bus primitives ----------------
    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic clock_bit(input logic d, output logic smp, output logic oe);
        sda_m = d;    wait_q();
        scl_m = 1'b1; wait_q();
        smp = sda_bus;
        oe  = sda_oe;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack, output logic oe_ack);
        logic s, o;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s, o);
        clock_bit(1'b1, s, oe_ack);
        ack = ~s;
    endtask

    task automatic recv_byte(input logic nack, input logic [7:0] next_tx, output logic [7:0] b);
        logic s, o;
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            clock_bit(1'b1, s, o);
            b = {b[6:0], s};
        end
        tx_data = next_tx;
        clock_bit(nack, s, o);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (sda_oe !== 1'b0)     begin failures++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
        checks++; if (rx_data !== 8'h00)   begin failures++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        checks++; if (rx_valid !== 1'b0)   begin failures++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
        checks++; if (tx_req !== 1'b0)     begin failures++; $display("FAIL reset_tx_req: got %b want 0", tx_req); end
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        rst = 1'b1;
        repeat (8) @(negedge clk);
        checks++; if (busy !== 1'b0 || sda_oe !== 1'b0) begin
            failures++; $display("FAIL reset_release_idle: got busy=%b oe=%b want 0/0", busy, sda_oe);
        end
    endtask

    task automatic test_write();
        logic ack, oe;
        int   rxv0;
        rxv0 = rxv_cnt;
        bus_start();
        send_byte(8'h84, ack, oe);
        checks++; if (ack !== 1'b1 || oe !== 1'b1) begin
            failures++; $display("FAIL write_addr_ack: got ack=%b oe=%b want 1/1", ack, oe);
        end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL write_busy: got %b want 1", busy); end
        send_byte(8'h5A, ack, oe);
        checks++; if (ack !== 1'b1 || oe !== 1'b1) begin
            failures++; $display("FAIL write_data_ack: got ack=%b oe=%b want 1/1", ack, oe);
        end
        exp_rx = 8'h5A;
        checks++; if (rx_data !== exp_rx) begin failures++; $display("FAIL write_rx_data: got %h want %h", rx_data, exp_rx); end
        checks++; if (rxv_cnt - rxv0 != 1) begin failures++; $display("FAIL write_rx_valid_count: got %0d want 1", rxv_cnt - rxv0); end
        // STOP with the busy-release deadline measured from the SDA rise.
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
        wait_q();
    endtask

    task automatic test_write_random();
        logic       ack, oe;
        logic [7:0] d;
        int         n, rxv0, nack_cnt;
        for (int t = 0; t < 4; t++) begin
            n        = $urandom_range(1, 4);
            rxv0     = rxv_cnt;
            nack_cnt = 0;
            bus_start();
            send_byte({ADDR_P, 1'b0}, ack, oe);
            if (ack !== 1'b1) nack_cnt++;
            for (int k = 0; k < n; k++) begin
                d = 8'($urandom);
                send_byte(d, ack, oe);
                if (ack !== 1'b1 || oe !== 1'b1) nack_cnt++;
                exp_rx = d;
            end
            bus_stop();
            checks++; if (nack_cnt != 0) begin failures++; $display("FAIL wr_rand_acks[%0d]: got %0d missing ACKs want 0", t, nack_cnt); end
            checks++; if (rx_data !== exp_rx) begin failures++; $display("FAIL wr_rand_rx_data[%0d]: got %h want %h", t, rx_data, exp_rx); end
            checks++; if (rxv_cnt - rxv0 != n) begin failures++; $display("FAIL wr_rand_rx_valid[%0d]: got %0d want %0d", t, rxv_cnt - rxv0, n); end
        end
    endtask

    task automatic test_read();
        logic       ack, oe;
        logic [7:0] b, r2;
        int         txr0, oe0;
        r2      = 8'($urandom);
        txr0    = txr_cnt;
        tx_data = 8'hC3;
        bus_start();
        send_byte(8'h85, ack, oe);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL read_addr_ack: got %b want 1", ack); end
        recv_byte(1'b0, r2, b);
        checks++; if (b !== 8'hC3) begin failures++; $display("FAIL read_byte0: got %h want c3", b); end
        recv_byte(1'b1, 8'h00, b);
        checks++; if (b !== r2) begin failures++; $display("FAIL read_byte1: got %h want %h", b, r2); end
        checks++; if (txr_cnt - txr0 != 2) begin failures++; $display("FAIL read_tx_req_count: got %0d want 2", txr_cnt - txr0); end
        checks++; if (sda_oe !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL read_after_nack: got oe=%b busy=%b want 0/0", sda_oe, busy);
        end
        // WAIT_STOP: further clocks are ignored.
        oe0 = oe_cnt;
        for (int i = 0; i < 9; i++) clock_bit(1'($urandom), ack, oe);
        checks++; if (oe_cnt != oe0) begin failures++; $display("FAIL read_wait_stop_quiet: got %0d oe cycles want 0", oe_cnt - oe0); end
        bus_stop();
    endtask

    task automatic test_read_random();
        logic       ack, oe;
        logic [7:0] q[$];
        logic [7:0] b;
        int         n, txr0, bad;
        for (int t = 0; t < 2; t++) begin
            n = $urandom_range(1, 3);
            q.delete();
            for (int k = 0; k < n; k++) q.push_back(8'($urandom));
            txr0    = txr_cnt;
            bad     = 0;
            tx_data = q[0];
            bus_start();
            send_byte({ADDR_P, 1'b1}, ack, oe);
            if (ack !== 1'b1) bad++;
            for (int k = 0; k < n; k++) begin
                recv_byte((k == n - 1), (k + 1 < n) ? q[k+1] : 8'($urandom), b);
                if (b !== q[k]) bad++;
            end
            bus_stop();
            checks++; if (bad != 0) begin failures++; $display("FAIL rd_rand_data[%0d]: got %0d bad bytes want 0", t, bad); end
            checks++; if (txr_cnt - txr0 != n) begin failures++; $display("FAIL rd_rand_tx_req[%0d]: got %0d want %0d", t, txr_cnt - txr0, n); end
        end
    endtask

    task automatic test_wrong_addr();
        logic       ack, oe;
        logic [7:0] addrs[4];
        int         oe0, rxv0, busy0;
        addrs[0] = 8'h90;
        addrs[1] = 8'h01;
        for (int i = 2; i < 4; i++) begin
            addrs[i] = 8'($urandom);
            while (model_ack(addrs[i])) addrs[i] = 8'($urandom);
        end
        for (int i = 0; i < 4; i++) begin
            oe0 = oe_cnt; rxv0 = rxv_cnt; busy0 = busy_cnt;
            bus_start();
            send_byte(addrs[i], ack, oe);
            send_byte(8'h11, ack, oe);
            bus_stop();
            checks++; if (oe_cnt != oe0) begin failures++; $display("FAIL wrong_addr_oe[%h]: got %0d oe cycles want 0", addrs[i], oe_cnt - oe0); end
            checks++; if (rxv_cnt != rxv0 || busy_cnt != busy0) begin
                failures++; $display("FAIL wrong_addr_quiet[%h]: got rxv=%0d busy=%0d want 0/0", addrs[i], rxv_cnt - rxv0, busy_cnt - busy0);
            end
        end
        checks++; if (rx_data !== exp_rx) begin failures++; $display("FAIL wrong_addr_rx_data: got %h want %h", rx_data, exp_rx); end
    endtask

    task automatic test_repeated_start();
        logic       ack, oe;
        logic [7:0] b, t;
        int         rxv0;
        t    = 8'($urandom);
        rxv0 = rxv_cnt;
        bus_start();
        send_byte({ADDR_P, 1'b0}, ack, oe);
        send_byte(8'h01, ack, oe);
        exp_rx = 8'h01;
        tx_data = t;
        bus_rstart();
        send_byte({ADDR_P, 1'b1}, ack, oe);
        checks++; if (ack !== 1'b1) begin failures++; $display("FAIL rstart_addr_ack: got %b want 1", ack); end
        recv_byte(1'b1, 8'h00, b);
        checks++; if (b !== t) begin failures++; $display("FAIL rstart_read: got %h want %h", b, t); end
        checks++; if (rx_data !== exp_rx) begin failures++; $display("FAIL rstart_rx_data: got %h want %h", rx_data, exp_rx); end
        checks++; if (rxv_cnt - rxv0 != 1) begin failures++; $display("FAIL rstart_rx_valid: got %0d want 1", rxv_cnt - rxv0); end
        bus_stop();
    endtask

    task automatic test_reset_mid();
        logic       ack, oe, s, o;
        logic [7:0] d1, d2, d3;
        int         oe0, busy0, rxv0;
        d1 = 8'($urandom_range(1, 255));
        d2 = 8'($urandom_range(1, 255));
        d3 = 8'($urandom_range(1, 255));
        bus_start();
        send_byte({ADDR_P, 1'b0}, ack, oe);
        send_byte(d1, ack, oe);
        for (int i = 7; i >= 0; i--) clock_bit(d2[i], s, o);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        checks++; if (sda_oe !== 1'b1) begin failures++; $display("FAIL rstmid_ack_driven: got %b want 1", sda_oe); end
        rst = 1'b0;
        #1;
        exp_rx = 8'h00;
        checks++; if (sda_oe !== 1'b0) begin failures++; $display("FAIL rstmid_sda_release: got %b want 0", sda_oe); end
        checks++; if (rx_data !== exp_rx || busy !== 1'b0) begin
            failures++; $display("FAIL rstmid_state: got rx=%h busy=%b want 00/0", rx_data, busy);
        end
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        wait_q();
        scl_m = 1'b0; wait_q();
        oe0 = oe_cnt; busy0 = busy_cnt; rxv0 = rxv_cnt;
        for (int i = 0; i < 18; i++) clock_bit(1'($urandom), s, o);
        checks++; if (oe_cnt != oe0 || busy_cnt != busy0 || rxv_cnt != rxv0) begin
            failures++; $display("FAIL rstmid_ignores_scl: got oe=%0d busy=%0d rxv=%0d want 0/0/0", oe_cnt - oe0, busy_cnt - busy0, rxv_cnt - rxv0);
        end
        bus_stop();
        bus_start();
        send_byte({ADDR_P, 1'b0}, ack, oe);
        send_byte(d3, s, o);
        exp_rx = d3;
        bus_stop();
        checks++; if (ack !== 1'b1 || s !== 1'b1 || rx_data !== exp_rx) begin
            failures++; $display("FAIL rstmid_recover: got ack=%b/%b rx=%h want 1/1/%h", ack, s, rx_data, exp_rx);
        end
    endtask

    task automatic test_general_call();
        logic ack_a, ack_d, oe_a, oe_d, exp_ack;
        exp_ack = model_ack(8'h00);
        bus_start();
        send_byte(8'h00, ack_a, oe_a);
        send_byte(8'h06, ack_d, oe_d);
        bus_stop();
        if (exp_ack) exp_rx = 8'h06;
        checks++; if (ack_a !== exp_ack || oe_a !== exp_ack) begin
            failures++; $display("FAIL gc_addr_ack: got ack=%b oe=%b want %b", ack_a, oe_a, exp_ack);
        end
        checks++; if (ack_d !== exp_ack) begin failures++; $display("FAIL gc_data_ack: got %b want %b", ack_d, exp_ack); end
        checks++; if (rx_data !== exp_rx) begin failures++; $display("FAIL gc_rx_data: got %h want %h", rx_data, exp_rx); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_random();
        test_read();
        test_read_random();
        test_wrong_addr();
        test_repeated_start();
        test_reset_mid();
        test_general_call();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
